// File: rtl/yuv_pkg.sv
// Shared constants for the YUV video path (4:2:2 upsampler and yuv2rgb stage).
//   PIX_W      : component width in bits
//   CHROMA_MID : neutral chroma value used when no chroma sample exists
//   LATENCY    : pixel latency of the 4:2:2 -> 4:4:4 converter
package yuv_pkg;

  localparam int PIX_W   = 8;
  localparam int LATENCY = 3;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t CHROMA_MID = 8'd128;

endpackage

// File: rtl/yuv422_to_yuv444_chroma_avg.sv
// chroma_avg: rounding average of two chroma samples, (a + b + 1) >> 1.
// The sum is carried at PIX_W+1 bits so 255 + 255 does not wrap; the
// rounding bit is folded back in as the sum's LSB, which gives the same
// result as adding 1 before the shift.
//   a_i, b_i : chroma samples to average
//   avg_o    : rounded mean
module chroma_avg
  import yuv_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] avg_o
);

  logic [PIX_W:0] w_sum;

  assign w_sum = {1'b0, a_i} + {1'b0, b_i};
  // ceil(sum/2) == (sum+1)>>1; cannot overflow PIX_W bits (max 255).
  assign avg_o = w_sum[PIX_W:1] + {{(PIX_W-1){1'b0}}, w_sum[0]};

endmodule

// File: rtl/yuv422_to_yuv444.sv
// yuv422_to_yuv444: 4:2:2 to 4:4:4 chroma upsampler with 3-cycle latency.
//
// Ports
//   clk_i    : pixel clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   vs_i     : vertical sync, delayed by LATENCY to vs_o
//   de_i     : data enable, one pixel per high cycle
//   y_ch_i   : luma
//   c_ch_i   : interleaved chroma, even pixels carry the "first" sample of a
//              pair (Cb when CB_FIRST=1, Cr when CB_FIRST=0)
//   vs_o/de_o: delayed sync/enable
//   y_ch_o, u_ch_o, v_ch_o : 4:4:4 pixel, all zero while de_o is low
//
// Build option
//   YUV422_INTERP_EN : when defined, odd pixels get the rounded mean of the
//                      current and next chroma pair instead of a replica of
//                      the current pair.
//
// Pipeline: inputs are registered into p0, p1, p2; the output pixel is formed
// from p1 while p0 (next pixel), p2 (previous pixel) and the live input
// (pixel after next) provide neighbouring chroma samples.
module yuv422_to_yuv444
  import yuv_pkg::*;
#(
  parameter int CB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [PIX_W-1:0] y_ch_i,
  input  logic [PIX_W-1:0] c_ch_i,
  output logic             vs_o,
  output logic             de_o,
  output logic [PIX_W-1:0] y_ch_o,
  output logic [PIX_W-1:0] u_ch_o,
  output logic [PIX_W-1:0] v_ch_o
);

  localparam bit CB_EVEN = (CB_FIRST != 0);

  logic               r_armed;
  logic               r_phase;
  logic               w_de_in;
  logic [LATENCY-1:0] r_vs_sr;

  logic               r_de_p0, r_de_p1, r_de_p2;
  logic               r_ph_p0, r_ph_p1;
  logic [PIX_W-1:0]   r_c_p0, r_c_p1, r_c_p2;
  logic [PIX_W-1:0]   r_y_p0, r_y_p1;

  logic               r_de_o;
  logic [PIX_W-1:0]   r_y_o, r_u_o, r_v_o;

  logic [PIX_W-1:0]   w_first, w_second;
  logic [PIX_W-1:0]   w_u_cur, w_v_cur;
  logic [PIX_W-1:0]   w_u_pix, w_v_pix;

  // A line already in progress when reset releases is dropped: pixels only
  // enter the pipeline once de_i has been seen low.
  assign w_de_in = de_i & r_armed;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_armed <= 1'b0;
      r_phase <= 1'b0;
      r_vs_sr <= '0;
    end else begin
      if (!de_i) begin
        r_armed <= 1'b1;
      end
      r_phase <= w_de_in ? ~r_phase : 1'b0;
      r_vs_sr <= {r_vs_sr[LATENCY-2:0], vs_i};
    end
  end

  // ---- stage p0 / p1 / p2: input delay line ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_de_p0 <= 1'b0;
      r_de_p1 <= 1'b0;
      r_de_p2 <= 1'b0;
      r_ph_p0 <= 1'b0;
      r_ph_p1 <= 1'b0;
      r_c_p0  <= '0;
      r_c_p1  <= '0;
      r_c_p2  <= '0;
      r_y_p0  <= '0;
      r_y_p1  <= '0;
    end else begin
      r_de_p0 <= w_de_in;
      r_ph_p0 <= r_phase;
      r_c_p0  <= c_ch_i;
      r_y_p0  <= y_ch_i;
      r_de_p1 <= r_de_p0;
      r_ph_p1 <= r_ph_p0;
      r_c_p1  <= r_c_p0;
      r_y_p1  <= r_y_p0;
      r_de_p2 <= r_de_p1;
      r_c_p2  <= r_c_p1;
    end
  end

  // Current pair for the pixel in p1. Adjacent de-high stages are always the
  // same line, so a neighbour is usable only when its own de bit is set.
  // Even pixel whose partner is missing (odd-width line end) borrows the
  // second sample of the previous pair, or mid-grey on a 1-pixel line.
  always_comb begin
    w_first  = r_c_p1;
    w_second = CHROMA_MID;
    if (r_ph_p1) begin
      w_first  = r_c_p2;
      w_second = r_c_p1;
    end else if (r_de_p0) begin
      w_second = r_c_p0;
    end else if (r_de_p2) begin
      w_second = r_c_p2;
    end
  end

  assign w_u_cur = CB_EVEN ? w_first  : w_second;
  assign w_v_cur = CB_EVEN ? w_second : w_first;

`ifdef YUV422_INTERP_EN
  logic [PIX_W-1:0] w_first_nxt, w_second_nxt;
  logic [PIX_W-1:0] w_u_nxt, w_v_nxt;
  logic [PIX_W-1:0] w_u_avg, w_v_avg;

  // Next pair for an odd pixel: p0 holds its first sample, the live input its
  // second. Missing samples fall back to the current pair.
  assign w_first_nxt  = r_de_p0 ? r_c_p0 : w_first;
  assign w_second_nxt = (r_de_p0 && w_de_in) ? c_ch_i : w_second;
  assign w_u_nxt      = CB_EVEN ? w_first_nxt  : w_second_nxt;
  assign w_v_nxt      = CB_EVEN ? w_second_nxt : w_first_nxt;

  chroma_avg u_avg_u (
    .a_i   (w_u_cur),
    .b_i   (w_u_nxt),
    .avg_o (w_u_avg)
  );

  chroma_avg u_avg_v (
    .a_i   (w_v_cur),
    .b_i   (w_v_nxt),
    .avg_o (w_v_avg)
  );

  assign w_u_pix = r_ph_p1 ? w_u_avg : w_u_cur;
  assign w_v_pix = r_ph_p1 ? w_v_avg : w_v_cur;
`else
  assign w_u_pix = w_u_cur;
  assign w_v_pix = w_v_cur;
`endif

  // ---- output stage ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_de_o <= 1'b0;
      r_y_o  <= '0;
      r_u_o  <= '0;
      r_v_o  <= '0;
    end else begin
      r_de_o <= r_de_p1;
      r_y_o  <= r_de_p1 ? r_y_p1  : '0;
      r_u_o  <= r_de_p1 ? w_u_pix : '0;
      r_v_o  <= r_de_p1 ? w_v_pix : '0;
    end
  end

  assign vs_o   = r_vs_sr[LATENCY-1];
  assign de_o   = r_de_o;
  assign y_ch_o = r_y_o;
  assign u_ch_o = r_u_o;
  assign v_ch_o = r_v_o;

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Bench for yuv422_to_yuv444: two instances (CB_FIRST=1 and CB_FIRST=0) share
// the stimulus; expected pixels come from a line-level model of the chroma
// pairing rules.
module tb_yuv422_to_yuv444;

  localparam int SEG_MAX = 64;
  localparam int LAT     = 3;

  logic       clk;
  logic       rst_n;
  logic       vs, de;
  logic [7:0] y, c;

  logic       vs1, de1, vs0, de0;
  logic [7:0] y1, u1, v1, y0, u0, v0;

  yuv422_to_yuv444 #(.CB_FIRST(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs), .de_i(de),
    .y_ch_i(y), .c_ch_i(c),
    .vs_o(vs1), .de_o(de1), .y_ch_o(y1), .u_ch_o(u1), .v_ch_o(v1)
  );

  yuv422_to_yuv444 #(.CB_FIRST(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs), .de_i(de),
    .y_ch_i(y), .c_ch_i(c),
    .vs_o(vs0), .de_o(de0), .y_ch_o(y0), .u_ch_o(u0), .v_ch_o(v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int s_de[SEG_MAX], s_vs[SEG_MAX], s_y[SEG_MAX], s_c[SEG_MAX];
  int e_de[SEG_MAX], e_vs[SEG_MAX], e_y[SEG_MAX];
  int e_u1[SEG_MAX], e_v1[SEG_MAX], e_u0[SEG_MAX], e_v0[SEG_MAX];
  int cap_u1[SEG_MAX], cap_v1[SEG_MAX], cap_u0[SEG_MAX], cap_v0[SEG_MAX];
  int cap_y1[SEG_MAX];
  int seg_len = 0;
  bit m_armed = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic put(input int d, input int yy, input int cc);
    s_de[seg_len] = d;
    s_y[seg_len]  = yy;
    s_c[seg_len]  = cc;
    s_vs[seg_len] = $urandom_range(0, 1);
    seg_len++;
  endtask

  // Line-level reference: find each line, split into pairs, apply the
  // neighbour/substitution rules directly on the sample list.
  task automatic model_seg();
    bit armed, line_ok;
    armed   = m_armed;
    line_ok = 1'b0;
    for (int i = 0; i < seg_len; i++) begin
      int s, e, len, k, m, f0, s0;
      e_de[i] = 0; e_y[i] = 0; e_vs[i] = s_vs[i];
      e_u1[i] = 0; e_v1[i] = 0; e_u0[i] = 0; e_v0[i] = 0;
      if (s_de[i] == 0) begin
        armed   = 1'b1;
        line_ok = 1'b0;
      end else begin
        if (i == 0 || s_de[i-1] == 0) line_ok = armed;
        if (line_ok) begin
          s = i;
          while (s > 0 && s_de[s-1] != 0) s--;
          e = i;
          while (e + 1 < seg_len && s_de[e+1] != 0) e++;
          len = e - s + 1;
          k   = i - s;
          m   = k / 2;
          f0  = s_c[s + 2*m];
          s0  = (2*m + 1 < len) ? s_c[s + 2*m + 1] : ((m > 0) ? s_c[s + 2*m - 1] : 128);
`ifdef YUV422_INTERP_EN
          if (k % 2 == 1) begin
            int f1, s1;
            f1 = (2*m + 2 < len) ? s_c[s + 2*m + 2] : f0;
            s1 = (2*m + 3 < len) ? s_c[s + 2*m + 3] : s0;
            f0 = (f0 + f1 + 1) / 2;
            s0 = (s0 + s1 + 1) / 2;
          end
`endif
          e_de[i] = 1;
          e_y[i]  = s_y[i];
          e_u1[i] = f0; e_v1[i] = s0;
          e_u0[i] = s0; e_v0[i] = f0;
        end
      end
    end
    m_armed = armed;
  endtask

  task automatic run_seg();
    model_seg();
    for (int j = 0; j < seg_len + LAT; j++) begin
      @(posedge clk);
      #1;
      if (j < seg_len) begin
        de = s_de[j][0]; vs = s_vs[j][0]; y = 8'(s_y[j]); c = 8'(s_c[j]);
      end else begin
        de = 1'b0; vs = 1'b0; y = 8'd0; c = 8'd0;
      end
      @(negedge clk);
      if (j >= LAT) begin
        int i;
        i = j - LAT;
        cap_y1[i] = int'(y1); cap_u1[i] = int'(u1); cap_v1[i] = int'(v1);
        cap_u0[i] = int'(u0); cap_v0[i] = int'(v0);
        chk_eq($sformatf("vs_o[%0d]", i),  32'(vs1), e_vs[i]);
        chk_eq($sformatf("de1[%0d]", i),   32'(de1), e_de[i]);
        chk_eq($sformatf("y1[%0d]", i),    32'(y1),  e_y[i]);
        chk_eq($sformatf("u1[%0d]", i),    32'(u1),  e_u1[i]);
        chk_eq($sformatf("v1[%0d]", i),    32'(v1),  e_v1[i]);
        chk_eq($sformatf("vs0[%0d]", i),   32'(vs0), e_vs[i]);
        chk_eq($sformatf("de0[%0d]", i),   32'(de0), e_de[i]);
        chk_eq($sformatf("y0[%0d]", i),    32'(y0),  e_y[i]);
        chk_eq($sformatf("u0[%0d]", i),    32'(u0),  e_u0[i]);
        chk_eq($sformatf("v0[%0d]", i),    32'(v0),  e_v0[i]);
      end
    end
  endtask

  task automatic gen_random();
    seg_len = 0;
    put(0, 0, 0);
    repeat (4) begin
      int w, g;
      w = $urandom_range(1, 9);
      g = $urandom_range(1, 3);
      for (int p = 0; p < w; p++)
        put(1, $urandom_range(0, 255),
            ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
      for (int p = 0; p < g; p++) put(0, 0, 0);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_eq({tag, "_vs1"}, 32'(vs1), 0);
    chk_eq({tag, "_de1"}, 32'(de1), 0);
    chk_eq({tag, "_y1"},  32'(y1),  0);
    chk_eq({tag, "_u1"},  32'(u1),  0);
    chk_eq({tag, "_v1"},  32'(v1),  0);
    chk_eq({tag, "_de0"}, 32'(de0), 0);
    chk_eq({tag, "_u0"},  32'(u0),  0);
    chk_eq({tag, "_v0"},  32'(v0),  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vs = 1'b0; de = 1'b0; y = 8'd0; c = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 4-pixel line
    seg_len = 0;
    put(0, 0, 0); put(1, 10, 100); put(1, 20, 200); put(1, 30, 110); put(1, 40, 210);
    put(0, 0, 0);
    run_seg();
    chk_eq("l4_p0_u", 32'(cap_u1[1]), 100);
    chk_eq("l4_p0_v", 32'(cap_v1[1]), 200);
    chk_eq("l4_p1_y", 32'(cap_y1[2]), 20);
`ifdef YUV422_INTERP_EN
    chk_eq("l4_p1_u", 32'(cap_u1[2]), 105);
    chk_eq("l4_p1_v", 32'(cap_v1[2]), 205);
`else
    chk_eq("l4_p1_u", 32'(cap_u1[2]), 100);
    chk_eq("l4_p1_v", 32'(cap_v1[2]), 200);
`endif
    chk_eq("l4_p3_u", 32'(cap_u1[4]), 110);
    chk_eq("l4_p3_v", 32'(cap_v1[4]), 210);

    // odd-width line then a 1-pixel line
    seg_len = 0;
    put(0, 0, 0); put(1, 10, 100); put(1, 20, 200); put(1, 30, 110);
    put(0, 0, 0); put(1, 50, 100); put(0, 0, 0);
    run_seg();
`ifdef YUV422_INTERP_EN
    chk_eq("odd_p1_u", 32'(cap_u1[2]), 105);
`else
    chk_eq("odd_p1_u", 32'(cap_u1[2]), 100);
`endif
    chk_eq("odd_p1_v", 32'(cap_v1[2]), 200);
    chk_eq("odd_p2_u", 32'(cap_u1[3]), 110);
    chk_eq("odd_p2_v", 32'(cap_v1[3]), 200);
    chk_eq("one_px_u", 32'(cap_u1[5]), 100);
    chk_eq("one_px_v", 32'(cap_v1[5]), 128);

    // back-to-back lines with a single-cycle gap
    seg_len = 0;
    put(0, 0, 0); put(1, 1, 200); put(1, 2, 100); put(0, 0, 0);
    put(1, 3, 50); put(1, 4, 60); put(0, 0, 0);
    run_seg();
    chk_eq("crf_u",    32'(cap_u0[1]), 100);
    chk_eq("crf_v",    32'(cap_v0[1]), 200);
    chk_eq("l2_p0_u0", 32'(cap_u0[4]), 60);
    chk_eq("l2_p0_v0", 32'(cap_v0[4]), 50);
    chk_eq("l2_p1_u0", 32'(cap_u0[5]), 60);
    chk_eq("l2_p1_v0", 32'(cap_v0[5]), 50);
    chk_eq("l2_p1_u1", 32'(cap_u1[5]), 50);
    chk_eq("l2_p1_v1", 32'(cap_v1[5]), 60);

    // reset pulsed in the middle of a 6-pixel line
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      de = (j < 6); vs = 1'b0;
      y = 8'(j + 1); c = 8'(j * 30 + 7);
      if (j == 2) begin
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
        if (j > 2) chk_eq($sformatf("midrst_de_off[%0d]", j), 32'(de1 | de0), 0);
      end
    end
    m_armed = 1'b0;
    seg_len = 0;
    put(0, 0, 0); put(1, 77, 11); put(1, 88, 22); put(1, 99, 33); put(0, 0, 0);
    run_seg();

    // randomized lines
    repeat (8) begin
      gen_random();
      run_seg();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/yuv422_to_yuv444.md
YUV422_TO_YUV444 -- requirements
Module: yuv422_to_yuv444

Interface
REQ-001 SHALL have parameter CB_FIRST, default 1: 1 = even-index chroma samples are Cb; 0 = even-index chroma samples are Cr.
REQ-002 SHALL have port clk_i  input  1  single pixel clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port vs_i  input  1  vertical sync, passed through.
REQ-005 SHALL have port de_i  input  1  data enable; one pixel per high cycle.
REQ-006 SHALL have port y_ch_i  input  8  luma of current pixel.
REQ-007 SHALL have port c_ch_i  input  8  interleaved 4:2:2 chroma (Cb/Cr alternating).
REQ-008 SHALL have port vs_o  output  1  vs_i delayed by 3 cycles.
REQ-009 SHALL have port de_o  output  1  de_i delayed by 3 cycles.
REQ-010 SHALL have ports y_ch_o, u_ch_o, v_ch_o  output  8 each  4:4:4 pixel for the downstream yuv2rgb stage.

Function
REQ-011 SHALL index pixels k = 0,1,2,... from each de_i rising edge; pair m = pixels (2m, 2m+1); Cb[m], Cr[m] taken from c_ch_i at k=2m and 2m+1 per CB_FIRST.
REQ-012 SHALL have a fixed latency of exactly 3 clk_i cycles from input pixel k to output pixel k, in both configurations.
REQ-013 SHALL output y_ch_o = y_ch_i of the same pixel, unmodified.
REQ-014 SHALL output, for even pixel 2m: u = Cb[m], v = Cr[m].
REQ-015 SHALL output, for odd pixel 2m+1 in replicate mode: u = Cb[m], v = Cr[m].
REQ-016 SHALL treat the first de_i-low cycle as line end; pixels after it are never used as neighbours.
REQ-017 SHALL, for an odd-width line, give the last pixel 2m: v = Cr[m-1]; if the line is 1 pixel wide, v = 128.
REQ-018 SHALL drive y_ch_o, u_ch_o, v_ch_o to 0 whenever de_o is low.
REQ-019 SHALL accept a de_i low gap of 1 cycle between lines with no loss or mixing of chroma across lines.
REQ-020 SHALL track pair phase with a 1-bit phase register, cleared on every de_i low cycle and toggled on every de_i high cycle.

Reset
REQ-021 SHALL, while rst_n_i is low, force vs_o, de_o, y_ch_o, u_ch_o, v_ch_o and all pipeline and phase state to 0.
REQ-022 SHALL, after reset release, keep de_o low until de_i has been sampled low at least once, discarding any partial line in progress.

Configuration
REQ-023 SHALL, with macro YUV422_INTERP_EN defined, compute odd pixel 2m+1 chroma as u = (Cb[m]+Cb[m+1]+1)>>1 and v = (Cr[m]+Cr[m+1]+1)>>1, using a 9-bit sum.
REQ-024 SHALL, with YUV422_INTERP_EN defined, substitute the pair-m sample for any pair-(m+1) sample that does not exist in the line.
REQ-025 SHALL, without YUV422_INTERP_EN, use replicate mode (REQ-015) and leave latency and ports unchanged.

Structure
REQ-026 SHALL take the constants PIX_W=8, CHROMA_MID=128 and LATENCY=3 from shared package yuv_pkg, which the yuv2rgb stage also uses.
REQ-027 SHALL implement rounding averaging in one sub-module, chroma_avg, instantiated twice (u, v) only when YUV422_INTERP_EN is defined.

Verification
REQ-028 SHALL cover: replicate mode, 4-pixel line, y=10,20,30,40, c=100,200,110,210 -> (10,100,200),(20,100,200),(30,110,210),(40,110,210); de_i high cycles 0-3 -> de_o high cycles 3-6.
REQ-029 SHALL cover: YUV422_INTERP_EN, same line -> pixel1 = (20,105,205), pixel3 = (40,110,210).
REQ-030 SHALL cover: odd width, y=10,20,30, c=100,200,110, interp -> (10,100,200),(20,105,200),(30,110,200); 1-pixel line c=100 -> u=100, v=128.
REQ-031 SHALL cover: CB_FIRST=0, c=200,100 -> u=100, v=200; back-to-back lines with a 1-cycle gap, second line c=50,60 -> no value 100/200 leaks into the second line.
REQ-032 SHALL cover: rst_n_i pulsed low at line pixel 2 -> outputs 0 immediately; de_o stays low for the rest of that line; next line output correct; vs_o follows vs_i with exactly 3-cycle delay.
